crypto_pack_arb: RTL and testbench

// - Arbitrates two requesters (issue ports 0/1) onto one shared crypto_pack datapath (PACK/PACKH/PACKW).
// - Registers the winner's operands, drives the combinational pack unit for one cycle, then holds the result until accepted.
// - Sits between the crypto issue logic and the writeback path.

---
 rtl/crypto_pack_arb.sv | 172 +++++++++++++++++
 tb/tb_crypto_pack_arb.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/crypto_pack_arb.sv
// Two-port arbiter feeding a shared PACK/PACKH/PACKW unit: capture, one execute cycle, hold result.
// Define CRYPTO_PACK_ARB_FIXED_PRIO_EN for fixed priority (port 0 always wins contention).
module crypto_pack_arb #(
    parameter int XLEN          = 64,
    parameter int TRANS_ID_BITS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,

    input  logic                     req0_valid_i,
    output logic                     req0_ready_o,
    input  logic [1:0]               req0_op_i,
    input  logic [XLEN-1:0]          req0_rs1_i,
    input  logic [XLEN-1:0]          req0_rs2_i,
    input  logic [TRANS_ID_BITS-1:0] req0_trans_id_i,

    input  logic                     req1_valid_i,
    output logic                     req1_ready_o,
    input  logic [1:0]               req1_op_i,
    input  logic [XLEN-1:0]          req1_rs1_i,
    input  logic [XLEN-1:0]          req1_rs2_i,
    input  logic [TRANS_ID_BITS-1:0] req1_trans_id_i,

    output logic [1:0]               pack_op_o,
    output logic [XLEN-1:0]          pack_rs1_o,
    output logic [XLEN-1:0]          pack_rs2_o,
    input  logic [XLEN-1:0]          pack_result_i,

    output logic                     result_valid_o,
    input  logic                     result_ready_i,
    output logic [XLEN-1:0]          result_o,
    output logic [TRANS_ID_BITS-1:0] result_trans_id_o,
    output logic                     result_src_o,
    output logic                     result_err_o,
    output logic                     busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_PACK    = 2'b00;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    state_t state;

    // Operand stage registers (drive the pack unit directly).
    logic [1:0]               op_p0;
    logic [XLEN-1:0]          rs1_p0;
    logic [XLEN-1:0]          rs2_p0;
    logic [TRANS_ID_BITS-1:0] id_p0;
    logic                     src_p0;
    logic                     err_p0;

    // Result stage registers.
    logic [XLEN-1:0]          res_p1;
    logic [TRANS_ID_BITS-1:0] id_p1;
    logic                     src_p1;
    logic                     err_p1;
    logic                     vld_p1;

`ifndef CRYPTO_PACK_ARB_FIXED_PRIO_EN
    logic last_grant;
`endif

    logic                     grant0;
    logic                     grant1;
    logic                     window;
    logic                     accept;
    logic [1:0]               sel_op;
    logic [XLEN-1:0]          sel_rs1;
    logic [XLEN-1:0]          sel_rs2;
    logic [TRANS_ID_BITS-1:0] sel_id;

    always_comb begin
`ifdef CRYPTO_PACK_ARB_FIXED_PRIO_EN
        grant0 = req0_valid_i;
`else
        // last_grant==1 means port 1 won last, so port 0 takes the next contention.
        grant0 = req0_valid_i & (~req1_valid_i | last_grant);
`endif
        grant1 = req1_valid_i & ~grant0;
    end

    assign window = ((state == IDLE) | ((state == RESP) & result_ready_i)) & ~flush_i & ~rst_i;

    assign req0_ready_o = grant0 & window;
    assign req1_ready_o = grant1 & window;
    assign accept       = req0_ready_o | req1_ready_o;

    assign sel_op  = grant1 ? req1_op_i       : req0_op_i;
    assign sel_rs1 = grant1 ? req1_rs1_i      : req0_rs1_i;
    assign sel_rs2 = grant1 ? req1_rs2_i      : req0_rs2_i;
    assign sel_id  = grant1 ? req1_trans_id_i : req0_trans_id_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            op_p0  <= '0;
            rs1_p0 <= '0;
            rs2_p0 <= '0;
            id_p0  <= '0;
            src_p0 <= 1'b0;
            err_p0 <= 1'b0;
            res_p1 <= '0;
            id_p1  <= '0;
            src_p1 <= 1'b0;
            err_p1 <= 1'b0;
            vld_p1 <= 1'b0;
`ifndef CRYPTO_PACK_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else if (flush_i) begin
            state  <= IDLE;
            vld_p1 <= 1'b0;
        end else begin
            // Capture on accept from either IDLE or RESP; an illegal op rides through as PACK with err set.
            if (accept) begin
                op_p0  <= (sel_op == OP_ILLEGAL) ? OP_PACK : sel_op;
                rs1_p0 <= sel_rs1;
                rs2_p0 <= sel_rs2;
                id_p0  <= sel_id;
                src_p0 <= grant1;
                err_p0 <= (sel_op == OP_ILLEGAL);
`ifndef CRYPTO_PACK_ARB_FIXED_PRIO_EN
                last_grant <= grant1;
`endif
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    // Execute / result stage boundary.
                    res_p1 <= err_p0 ? '0 : pack_result_i;
                    id_p1  <= id_p0;
                    src_p1 <= src_p0;
                    err_p1 <= err_p0;
                    vld_p1 <= 1'b1;
                    state  <= RESP;
                end
                RESP: begin
                    if (result_ready_i) begin
                        vld_p1 <= 1'b0;
                        state  <= accept ? EXEC : IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    vld_p1 <= 1'b0;
                end
            endcase
        end
    end

    assign pack_op_o         = op_p0;
    assign pack_rs1_o        = rs1_p0;
    assign pack_rs2_o        = rs2_p0;
    assign result_valid_o    = vld_p1;
    assign result_o          = res_p1;
    assign result_trans_id_o = id_p1;
    assign result_src_o      = src_p1;
    assign result_err_o      = err_p1;
    assign busy_o            = (state != IDLE);

endmodule

// File: tb/tb_crypto_pack_arb.sv
// Directed bench for crypto_pack_arb: table of single-port operations plus arbitration, stall, flush and reset sequences.
module tb_crypto_pack_arb;

    localparam int XLEN = 64;
    localparam int TIDB = 3;

    logic            clk = 1'b0;
    logic            rst_i, flush_i;
    logic            req0_valid_i, req0_ready_o;
    logic [1:0]      req0_op_i;
    logic [XLEN-1:0] req0_rs1_i, req0_rs2_i;
    logic [TIDB-1:0] req0_trans_id_i;
    logic            req1_valid_i, req1_ready_o;
    logic [1:0]      req1_op_i;
    logic [XLEN-1:0] req1_rs1_i, req1_rs2_i;
    logic [TIDB-1:0] req1_trans_id_i;
    logic [1:0]      pack_op_o;
    logic [XLEN-1:0] pack_rs1_o, pack_rs2_o, pack_result_i;
    logic            result_valid_o, result_ready_i;
    logic [XLEN-1:0] result_o;
    logic [TIDB-1:0] result_trans_id_o;
    logic            result_src_o, result_err_o, busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    crypto_pack_arb #(.XLEN(XLEN), .TRANS_ID_BITS(TIDB)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_op_i(req0_op_i),
        .req0_rs1_i(req0_rs1_i), .req0_rs2_i(req0_rs2_i), .req0_trans_id_i(req0_trans_id_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_op_i(req1_op_i),
        .req1_rs1_i(req1_rs1_i), .req1_rs2_i(req1_rs2_i), .req1_trans_id_i(req1_trans_id_i),
        .pack_op_o(pack_op_o), .pack_rs1_o(pack_rs1_o), .pack_rs2_o(pack_rs2_o),
        .pack_result_i(pack_result_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i), .result_o(result_o),
        .result_trans_id_o(result_trans_id_o), .result_src_o(result_src_o),
        .result_err_o(result_err_o), .busy_o(busy_o)
    );

    // Behavioural model of the external combinational pack unit.
    logic [31:0] packw_word;
    always_comb begin
        packw_word = {pack_rs2_o[15:0], pack_rs1_o[15:0]};
        case (pack_op_o)
            2'b00:   pack_result_i = {pack_rs2_o[31:0], pack_rs1_o[31:0]};
            2'b01:   pack_result_i = {{32{packw_word[31]}}, packw_word};
            2'b10:   pack_result_i = {48'd0, pack_rs2_o[7:0], pack_rs1_o[7:0]};
            default: pack_result_i = '0;
        endcase
    end

    typedef struct {
        logic            port;
        logic [1:0]      op;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [TIDB-1:0] id;
        logic [1:0]      exp_pack_op;
        logic [XLEN-1:0] exp_res;
        logic            exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic port, input logic [1:0] op, input logic [XLEN-1:0] rs1,
                             input logic [XLEN-1:0] rs2, input logic [TIDB-1:0] id);
        if (port) begin
            req1_valid_i = 1'b1; req1_op_i = op; req1_rs1_i = rs1; req1_rs2_i = rs2; req1_trans_id_i = id;
        end else begin
            req0_valid_i = 1'b1; req0_op_i = op; req0_rs1_i = rs1; req0_rs2_i = rs2; req0_trans_id_i = id;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_p;
        logic [XLEN-1:0] held;

        vecs[0] = '{1'b0, 2'b00, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 3'd5,
                    2'b00, 64'h7777_8888_3333_4444, 1'b0};
        vecs[1] = '{1'b1, 2'b01, 64'hDEAD_BEEF_0000_8001, 64'hCAFE_BABE_0000_9002, 3'd2,
                    2'b01, 64'hFFFF_FFFF_9002_8001, 1'b0};
        vecs[2] = '{1'b0, 2'b10, 64'h0000_0000_0000_00AB, 64'h0000_0000_0000_00CD, 3'd1,
                    2'b10, 64'h0000_0000_0000_CDAB, 1'b0};
        vecs[3] = '{1'b1, 2'b11, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 3'd6,
                    2'b00, 64'h0, 1'b1};
        vecs[4] = '{1'b0, 2'b00, 64'hFFFF_FFFF_0000_0001, 64'h0000_0000_8000_0000, 3'd7,
                    2'b00, 64'h8000_0000_0000_0001, 1'b0};
        vecs[5] = '{1'b1, 2'b01, 64'h0000_0000_0000_1234, 64'h1111_1111_0000_7654, 3'd3,
                    2'b01, 64'h0000_0000_7654_1234, 1'b0};

        rst_i = 1'b1; flush_i = 1'b0; result_ready_i = 1'b0;
        req0_valid_i = 1'b0; req0_op_i = '0; req0_rs1_i = '0; req0_rs2_i = '0; req0_trans_id_i = '0;
        req1_valid_i = 1'b0; req1_op_i = '0; req1_rs1_i = '0; req1_rs2_i = '0; req1_trans_id_i = '0;

        // Reset state, and no accept while reset is held.
        req0_valid_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready0", 64'(req0_ready_o), 64'd0);
        chk("rst_valid", 64'(result_valid_o), 64'd0);
        chk("rst_result", result_o, 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_pack_op", 64'(pack_op_o), 64'd0);
        chk("rst_pack_rs1", pack_rs1_o, 64'd0);
        chk("rst_tid", 64'(result_trans_id_o), 64'd0);
        chk("rst_err_src", 64'({result_err_o, result_src_o}), 64'd0);
        @(negedge clk);
        rst_i = 1'b0; req0_valid_i = 1'b0;

        // Single-port operations: accept at N, EXEC at N+1, result at N+2.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive_req(vecs[i].port, vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].id);
            #1;
            chk("vec_ready_win", 64'(vecs[i].port ? req1_ready_o : req0_ready_o), 64'd1);
            chk("vec_ready_lose", 64'(vecs[i].port ? req0_ready_o : req1_ready_o), 64'd0);
            @(negedge clk);
            req0_valid_i = 1'b0; req1_valid_i = 1'b0;
            #1;
            chk("vec_exec_busy", 64'(busy_o), 64'd1);
            chk("vec_exec_valid", 64'(result_valid_o), 64'd0);
            chk("vec_pack_op", 64'(pack_op_o), 64'(vecs[i].exp_pack_op));
            chk("vec_pack_rs1", pack_rs1_o, vecs[i].rs1);
            @(negedge clk);
            #1;
            chk("vec_valid", 64'(result_valid_o), 64'd1);
            chk("vec_result", result_o, vecs[i].exp_res);
            chk("vec_tid", 64'(result_trans_id_o), 64'(vecs[i].id));
            chk("vec_src", 64'(result_src_o), 64'(vecs[i].port));
            chk("vec_err", 64'(result_err_o), 64'(vecs[i].exp_err));
            result_ready_i = 1'b1;
            @(negedge clk);
            result_ready_i = 1'b0;
            #1;
            chk("vec_done_valid", 64'(result_valid_o), 64'd0);
            chk("vec_done_busy", 64'(busy_o), 64'd0);
        end

        // Contention with both ports valid continuously after a fresh reset.
        @(negedge clk); rst_i = 1'b1;
        @(negedge clk); rst_i = 1'b0;
        drive_req(1'b0, 2'b00, 64'h10, 64'h20, 3'd2);
        drive_req(1'b1, 2'b00, 64'h30, 64'h40, 3'd6);
        result_ready_i = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
`ifdef CRYPTO_PACK_ARB_FIXED_PRIO_EN
            exp_p = 1'b0;
`else
            exp_p = k[0];
`endif
            chk("rr_ready0", 64'(req0_ready_o), 64'(!exp_p));
            chk("rr_ready1", 64'(req1_ready_o), 64'(exp_p));
            @(negedge clk); #1;
            chk("rr_exec_noready", 64'(req0_ready_o | req1_ready_o), 64'd0);
            @(negedge clk); #1;
            chk("rr_valid", 64'(result_valid_o), 64'd1);
            chk("rr_src", 64'(result_src_o), 64'(exp_p));
            chk("rr_tid", 64'(result_trans_id_o), exp_p ? 64'd6 : 64'd2);
        end
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        @(negedge clk);
        result_ready_i = 1'b0;
        #1;
        chk("rr_end_busy", 64'(busy_o), 64'd0);

        // Writeback stall: result held, no accepts; release accepts pending req1 in the same cycle.
        @(negedge clk);
        drive_req(1'b0, 2'b00, 64'h1, 64'h2, 3'd3);
        #1;
        chk("stall_ready0", 64'(req0_ready_o), 64'd1);
        @(negedge clk);
        req0_valid_i = 1'b0;
        drive_req(1'b1, 2'b10, 64'h12, 64'h34, 3'd4);
        #1;
        chk("stall_exec_ready1", 64'(req1_ready_o), 64'd0);
        @(negedge clk); #1;
        held = 64'h0000_0002_0000_0001;
        for (int j = 0; j < 5; j++) begin
            chk("stall_valid", 64'(result_valid_o), 64'd1);
            chk("stall_result", result_o, held);
            chk("stall_tid", 64'(result_trans_id_o), 64'd3);
            chk("stall_noready", 64'(req0_ready_o | req1_ready_o), 64'd0);
            @(negedge clk); #1;
        end
        result_ready_i = 1'b1;
        #1;
        chk("stall_release_ready1", 64'(req1_ready_o), 64'd1);
        @(negedge clk);
        req1_valid_i = 1'b0; result_ready_i = 1'b0;
        #1;
        chk("stall_next_exec", 64'({busy_o, result_valid_o}), 64'b10);
        chk("stall_next_op", 64'(pack_op_o), 64'd2);
        @(negedge clk); #1;
        chk("stall_next_valid", 64'(result_valid_o), 64'd1);
        chk("stall_next_result", result_o, 64'h3412);
        chk("stall_next_src", 64'(result_src_o), 64'd1);
        result_ready_i = 1'b1;
        @(negedge clk);
        result_ready_i = 1'b0;

        // Flush during EXEC drops the operation; flush in IDLE blocks accept.
        @(negedge clk);
        drive_req(1'b0, 2'b00, 64'h5, 64'h6, 3'd1);
        #1;
        chk("flush_accept", 64'(req0_ready_o), 64'd1);
        @(negedge clk);
        req0_valid_i = 1'b0; flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        chk("flush_valid", 64'(result_valid_o), 64'd0);
        chk("flush_busy", 64'(busy_o), 64'd0);
        @(negedge clk); #1;
        chk("flush_stays_invalid", 64'(result_valid_o), 64'd0);
        flush_i = 1'b1;
        drive_req(1'b0, 2'b00, 64'h7, 64'h8, 3'd2);
        #1;
        chk("flush_idle_ready0", 64'(req0_ready_o), 64'd0);
        @(negedge clk);
        flush_i = 1'b0; req0_valid_i = 1'b0;
        #1;
        chk("flush_idle_busy", 64'(busy_o), 64'd0);

        // Reset while holding a result clears everything and restores port 0 priority.
        @(negedge clk);
        drive_req(1'b0, 2'b00, 64'hAAAA, 64'hBBBB, 3'd7);
        #1;
        chk("rstresp_accept", 64'(req0_ready_o), 64'd1);
        @(negedge clk);
        req0_valid_i = 1'b0;
        @(negedge clk); #1;
        chk("rstresp_valid_before", 64'(result_valid_o), 64'd1);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        chk("rstresp_valid", 64'(result_valid_o), 64'd0);
        chk("rstresp_result", result_o, 64'd0);
        chk("rstresp_tid", 64'(result_trans_id_o), 64'd0);
        chk("rstresp_pack_rs1", pack_rs1_o, 64'd0);
        chk("rstresp_busy", 64'(busy_o), 64'd0);
        drive_req(1'b0, 2'b00, 64'h1, 64'h1, 3'd0);
        drive_req(1'b1, 2'b00, 64'h2, 64'h2, 3'd1);
        #1;
        chk("rstresp_ready0", 64'(req0_ready_o), 64'd1);
        chk("rstresp_ready1", 64'(req1_ready_o), 64'd0);
        @(negedge clk);
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        @(negedge clk);
        #1;
        chk("rstresp_src", 64'(result_src_o), 64'd0);
        result_ready_i = 1'b1;
        @(negedge clk);
        result_ready_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
